// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and ID-width helper for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search, lowest index at or above ptr, wrapping
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);
  always_comb begin
    found = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) idx = IDW'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding one shared FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int IDW      = id_width(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]       i_req_last,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [IDW+WIDTH-1:0]     o_fifo_wdata,
  output logic                     o_fifo_wen,
  input  logic                     i_fifo_full,
  output logic [IDW-1:0]           o_grant_id,
  output logic                     o_busy
);
  localparam int BW = $clog2(MAX_BURST) + 1;
  state_t state;
  logic [IDW-1:0] owner, rr_ptr, pick;
  logic [BW-1:0] beats;
  logic found, active, done;
  rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
    .req(i_req_valid), .ptr(rr_ptr), .found(found), .idx(pick)
  );
  // reset gates the handshake so a mid-burst reset never writes
  assign active = state == GRANT && !i_rst;
  assign o_busy = state == GRANT;
  assign o_grant_id = owner;
  assign o_req_ready = (active && !i_fifo_full) ? NUM_REQ'(1) << owner : '0;
  assign o_fifo_wen = active && i_req_valid[owner] && !i_fifo_full;
  assign o_fifo_wdata = {owner, i_req_data[owner*WIDTH +: WIDTH]};
  assign done = i_req_last[owner] || beats == BW'(MAX_BURST - 1);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      beats <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        owner <= pick;
        beats <= '0;
        state <= GRANT;
      end
    end else if (o_fifo_wen) begin
      beats <= beats + 1'b1;
      if (done) begin
        state <= IDLE;
        rr_ptr <= owner == IDW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
      end
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..16).
REQ-002 SHALL have parameter WIDTH, default 8, meaning requester data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning maximum beats per grant (power of 2, >=1).
REQ-004 SHALL have localparam IDW = $clog2(NUM_REQ), meaning requester-ID width.
REQ-005 i_clk  input  1  clock; all logic on rising edge.
REQ-006 i_rst  input  1  reset, synchronous, active-high.
REQ-007 i_req_valid  input  NUM_REQ  per-requester beat valid.
REQ-008 i_req_data  input  NUM_REQ*WIDTH  packed beat data; requester k in bits [k*WIDTH +: WIDTH].
REQ-009 i_req_last  input  NUM_REQ  per-requester last-beat-of-burst flag.
REQ-010 o_req_ready  output  NUM_REQ  per-requester beat accepted this cycle when valid&ready.
REQ-011 o_fifo_wdata  output  IDW+WIDTH  {owner ID, data} to shared FIFO write port.
REQ-012 o_fifo_wen  output  1  FIFO write enable.
REQ-013 i_fifo_full  input  1  FIFO full flag.
REQ-014 o_grant_id  output  IDW  current owner ID; valid while o_busy.
REQ-015 o_busy  output  1  high while in state GRANT.

Function
REQ-016 SHALL implement FSM with states IDLE and GRANT.
REQ-017 IDLE: if any i_req_valid bit is high, SHALL select owner by round-robin starting from rr_ptr (lowest index at or above rr_ptr, wrapping), register it, and enter GRANT next cycle; otherwise remain IDLE.
REQ-018 IDLE: o_req_ready SHALL be all zero and o_fifo_wen SHALL be 0.
REQ-019 GRANT: o_req_ready[owner] SHALL equal ~i_fifo_full combinationally; all other ready bits SHALL be 0.
REQ-020 GRANT: o_fifo_wen SHALL equal i_req_valid[owner] & ~i_fifo_full; o_fifo_wdata SHALL equal {owner, i_req_data[owner]}.
REQ-021 Each write SHALL increment a beat counter (width $clog2(MAX_BURST)+1, cleared on entering GRANT).
REQ-022 GRANT SHALL return to IDLE the cycle after a write with i_req_last[owner]=1 or with beat counter reaching MAX_BURST; rr_ptr SHALL then become (owner+1) mod NUM_REQ.
REQ-023 GRANT SHALL hold (no exit, no timeout) while owner's valid is low or i_fifo_full is high.
REQ-024 Arbitration latency: exactly one idle bubble cycle between consecutive grants.
REQ-025 o_fifo_wen SHALL never be high while i_fifo_full is high.
REQ-026 Beats from different requesters SHALL never interleave within one grant.
REQ-027 Changes to non-owner valid bits during GRANT SHALL have no effect until next IDLE.

Reset
REQ-028 On i_rst: state=IDLE, rr_ptr=0, owner=0, beat counter=0; o_busy=0, o_grant_id=0, o_req_ready=0, o_fifo_wen=0.
REQ-029 Reset asserted mid-burst SHALL abort the grant with no write in the reset cycle; no partial-burst recovery.

Structure
REQ-030 Package fifo_arb_pkg SHALL hold the state enum (IDLE, GRANT) and the ID-width helper function.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req vector, rr_ptr; outputs found, index).
REQ-032 Block SHALL connect directly to the team FIFO (WIDTH = IDW+WIDTH) with no extra buffering.

Verification
REQ-033 Req0 sends 3 beats (last on 3rd), FIFO empty -> grant cycle 1, writes cycles 2-4, wdata ID=0, IDLE cycle 5, rr_ptr=1.
REQ-034 All 4 requesters valid continuously, single-beat bursts -> grant order 0,1,2,3,0, one bubble between each.
REQ-035 Req2 sends 6 beats, no last, MAX_BURST=4 -> 4 writes, release, other valid requester granted next; req2 resumes later.
REQ-036 i_fifo_full high 3 cycles mid-burst -> o_fifo_wen=0 and ready=0 those cycles, no beat lost, owner unchanged.
REQ-037 i_rst asserted after 2nd beat of 4 -> next cycle busy=0, wen=0, rr_ptr=0; following grant starts from req0.
REQ-038 Owner drops valid 2 cycles mid-burst while req1 valid -> grant held, no write, req1 not granted until last.
